// File: rtl/snes_button_events.sv
// SNES button event unit: per-frame debounce of the controller button vector,
// press/release event generation in ascending button order, and a small
// first-word fall-through event FIFO popped by the CPU.
module snes_button_events #(
    parameter int unsigned BTN_W      = 12,
    parameter int unsigned DEB_FRAMES = 3,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BTN_W-1:0] button_data,
    input  logic             frame_latch,
    input  logic             rd_en,
    input  logic             clr_ovf,
    output logic [4:0]       ev_data,
    output logic             ev_empty,
    output logic [AW:0]      ev_count,
    output logic             ev_overflow,
    output logic [BTN_W-1:0] held
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    localparam logic [3:0] LastIdx = 4'(BTN_W - 1);

    logic             sync1_q, sync2_q, edge_q;
    logic             frame_tick, launch;
    logic             pending_q, pending_d;
    logic             deb_stb_q, deb_done_q;
    logic [BTN_W-1:0] snapshot_q;
    logic [BTN_W-1:0] held_q, held_d;
    logic [BTN_W-1:0] chg_q, chg_d;
    logic [3:0]       cnt_q [BTN_W];
    logic [3:0]       cnt_d [BTN_W];
    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;

    logic [4:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q;
    logic             push, pop, wr, drop, full;

    assign frame_tick = sync2_q & ~edge_q;

    // A frame is processed only when the whole debounce/scan pipeline is free;
    // otherwise one tick is remembered in pending and launched once it frees up.
    assign launch = (frame_tick | pending_q) && (state_q == StIdle) && !deb_stb_q && !deb_done_q;

    // Pending flag next state (one deep; extra ticks are dropped).
    always_comb begin
        pending_d = pending_q;
        if (launch) begin
            pending_d = pending_q & frame_tick;
        end else if (frame_tick) begin
            pending_d = 1'b1;
        end
    end

    // Latch synchroniser, edge detect, snapshot and debounce pipeline strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            pending_q  <= 1'b0;
            deb_stb_q  <= 1'b0;
            deb_done_q <= 1'b0;
            snapshot_q <= '0;
        end else begin
            sync1_q    <= frame_latch;
            sync2_q    <= sync1_q;
            edge_q     <= sync2_q;
            pending_q  <= pending_d;
            deb_stb_q  <= launch;
            deb_done_q <= deb_stb_q;
            if (launch) begin
                snapshot_q <= button_data;
            end
        end
    end

    // Per-button debounce: held flips after DEB_FRAMES consecutive differing snapshots.
    always_comb begin
        held_d = held_q;
        chg_d  = chg_q;
        for (int i = 0; i < BTN_W; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (deb_stb_q) begin
            chg_d = '0;
            for (int i = 0; i < BTN_W; i++) begin
                if (snapshot_q[i] == held_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] + 4'd1 == 4'(DEB_FRAMES)) begin
                    cnt_d[i]  = 4'd0;
                    held_d[i] = ~held_q[i];
                    chg_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_q <= '0;
            chg_q  <= '0;
            for (int i = 0; i < BTN_W; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            held_q <= held_d;
            chg_q  <= chg_d;
            for (int i = 0; i < BTN_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Scan FSM next state: walk indices 0..BTN_W-1 after each debounce update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (deb_done_q) begin
                    state_d = StScan;
                    idx_d   = 4'd0;
                end
            end
            StScan: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FIFO control: a pop frees the slot a simultaneous push needs, even when full.
    always_comb begin
        push    = (state_q == StScan) && chg_q[idx_q];
        full    = (count_q == (AW + 1)'(FIFO_DEPTH));
        pop     = rd_en && (count_q != '0);
        wr      = push && (!full || pop);
        drop    = push && full && !pop;
        count_d = count_q;
        if (wr && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are never observed while empty, so no reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wptr_q] <= {held_q[idx_q], idx_q};
        end
    end

    assign ev_empty    = (count_q == '0);
    assign ev_data     = ev_empty ? 5'd0 : mem_q[rptr_q];
    assign ev_count    = count_q;
    assign ev_overflow = ovf_q;
    assign held        = held_q;

endmodule

// File: tb/tb_snes_button_events.sv
// Self-checking bench for snes_button_events: directed scenarios plus random
// frames compared against a per-frame behavioural model of buttons and events.
module tb_snes_button_events;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] button_data = '0;
    logic        frame_latch = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [4:0]  ev_data;
    logic        ev_empty;
    logic [3:0]  ev_count;
    logic        ev_overflow;
    logic [11:0] held;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: debounced state, run lengths of differing frames, event queue.
    logic [11:0] m_held = '0;
    int          m_run[12];
    logic [4:0]  m_q[$];
    bit          m_ovf = 1'b0;

    snes_button_events dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .button_data (button_data),
        .frame_latch (frame_latch),
        .rd_en       (rd_en),
        .clr_ovf     (clr_ovf),
        .ev_data     (ev_data),
        .ev_empty    (ev_empty),
        .ev_count    (ev_count),
        .ev_overflow (ev_overflow),
        .held        (held)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_held = '0;
        for (int i = 0; i < 12; i++) m_run[i] = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endfunction

    // One processed frame: a button flips after 3 consecutive differing frames.
    function automatic void model_frame(input logic [11:0] val);
        for (int i = 0; i < 12; i++) begin
            if (val[i] != m_held[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == 3) begin
                    m_held[i] = val[i];
                    m_run[i]  = 0;
                    if (m_q.size() < 8) m_q.push_back({val[i], 4'(i)});
                    else m_ovf = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endfunction

    function automatic logic [4:0] m_head();
        return (m_q.size() == 0) ? 5'd0 : m_q[0];
    endfunction

    // One latch pulse and enough idle time for the scan; optional pop across posedge pop_at.
    task automatic do_frame(input logic [11:0] val, input int pop_at);
        @(negedge clk);
        button_data = val;
        frame_latch = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 3) begin
                frame_latch = 1'b0;
                button_data = 12'($urandom);
            end
            if (pop_at > 0 && k == pop_at - 1) rd_en = 1'b1;
            if (k == pop_at) rd_en = 1'b0;
        end
    endtask

    task automatic pop_one(output logic [4:0] d);
        @(negedge clk);
        d = ev_data;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (held !== 12'h000) $display("FAIL reset_held: got %h want 000", held); else n_pass++;
        n_checks++; if (ev_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", ev_count); else n_pass++;
        n_checks++; if (ev_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", ev_empty); else n_pass++;
        n_checks++; if (ev_data !== 5'h00) $display("FAIL reset_data: got %h want 00", ev_data); else n_pass++;
        n_checks++; if (ev_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ev_overflow); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_single_press();
        logic [4:0] d;
        for (int f = 1; f <= 3; f++) begin
            do_frame(12'h001, 0);
            model_frame(12'h001);
            if (f < 3) begin
                n_checks++; if (ev_count !== 4'd0) $display("FAIL press_early_count: got %0d want 0", ev_count); else n_pass++;
                n_checks++; if (held !== 12'h000) $display("FAIL press_early_held: got %h want 000", held); else n_pass++;
            end
        end
        n_checks++; if (held !== 12'h001) $display("FAIL press_held: got %h want 001", held); else n_pass++;
        n_checks++; if (ev_count !== 4'd1) $display("FAIL press_count: got %0d want 1", ev_count); else n_pass++;
        n_checks++; if (ev_data !== 5'h10) $display("FAIL press_data: got %h want 10", ev_data); else n_pass++;
        while (m_q.size() > 0) begin
            pop_one(d);
            n_checks++; if (d !== m_q[0]) $display("FAIL press_pop: got %h want %h", d, m_q[0]); else n_pass++;
            void'(m_q.pop_front());
        end
    endtask

    task automatic test_release_debounce();
        logic [4:0] d;
        do_frame(12'h000, 0); model_frame(12'h000);
        do_frame(12'h000, 0); model_frame(12'h000);
        do_frame(12'h001, 0); model_frame(12'h001);
        n_checks++; if (ev_count !== 4'd0) $display("FAIL bounce_count: got %0d want 0", ev_count); else n_pass++;
        n_checks++; if (held !== 12'h001) $display("FAIL bounce_held: got %h want 001", held); else n_pass++;
        for (int f = 0; f < 3; f++) begin
            do_frame(12'h000, 0);
            model_frame(12'h000);
        end
        n_checks++; if (ev_count !== 4'd1) $display("FAIL release_count: got %0d want 1", ev_count); else n_pass++;
        n_checks++; if (ev_data !== 5'h00 || ev_empty !== 1'b0) $display("FAIL release_data: got %h/%b want 00/0", ev_data, ev_empty); else n_pass++;
        n_checks++; if (held !== 12'h000) $display("FAIL release_held: got %h want 000", held); else n_pass++;
        pop_one(d);
        n_checks++; if (d !== 5'h00) $display("FAIL release_pop: got %h want 00", d); else n_pass++;
        void'(m_q.pop_front());
    endtask

    task automatic test_timing();
        int first = -1;
        int second = -1;
        logic [4:0] d;
        do_frame(12'h900, 0); model_frame(12'h900);
        do_frame(12'h900, 0); model_frame(12'h900);
        @(negedge clk);
        button_data = 12'h900;
        frame_latch = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) frame_latch = 1'b0;
            if (first < 0 && ev_count == 4'd1) first = k;
            if (second < 0 && ev_count == 4'd2) second = k;
        end
        model_frame(12'h900);
        n_checks++; if (first != 14) $display("FAIL timing_first: got cycle %0d want 14", first); else n_pass++;
        n_checks++; if (second - first != 3) $display("FAIL timing_gap: got %0d want 3", second - first); else n_pass++;
        pop_one(d);
        n_checks++; if (d !== 5'h18) $display("FAIL timing_ev_a: got %h want 18", d); else n_pass++;
        pop_one(d);
        n_checks++; if (d !== 5'h1B) $display("FAIL timing_ev_r: got %h want 1b", d); else n_pass++;
        m_q.delete();
        @(negedge clk);
        n_checks++; if (ev_empty !== 1'b1 || ev_data !== 5'h00) $display("FAIL timing_empty: got %b/%h want 1/00", ev_empty, ev_data); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int f = 0; f < 3; f++) begin
            do_frame(12'hFFF, 0);
            model_frame(12'hFFF);
        end
        n_checks++; if (ev_count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", ev_count); else n_pass++;
        n_checks++; if (ev_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ev_overflow); else n_pass++;
        n_checks++; if (ev_data !== 5'h10) $display("FAIL ovf_head: got %h want 10", ev_data); else n_pass++;
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        m_ovf = 1'b0;
        n_checks++; if (ev_overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ev_overflow); else n_pass++;
        n_checks++; if (ev_count !== 4'd8) $display("FAIL ovf_clear_count: got %0d want 8", ev_count); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [4:0] d;
        do_frame(12'hFFE, 0); model_frame(12'hFFE);
        do_frame(12'hFFE, 0); model_frame(12'hFFE);
        // idx 0 is pushed at the 6th edge after the latch rises; pop on that same edge
        do_frame(12'hFFE, 6);
        void'(m_q.pop_front());
        model_frame(12'hFFE);
        n_checks++; if (ev_count !== 4'd8) $display("FAIL full_pp_count: got %0d want 8", ev_count); else n_pass++;
        n_checks++; if (ev_overflow !== 1'b0) $display("FAIL full_pp_ovf: got %b want 0", ev_overflow); else n_pass++;
        n_checks++; if (ev_data !== m_head()) $display("FAIL full_pp_head: got %h want %h", ev_data, m_head()); else n_pass++;
        while (m_q.size() > 0) begin
            pop_one(d);
            n_checks++; if (d !== m_q[0]) $display("FAIL full_pp_drain: got %h want %h", d, m_q[0]); else n_pass++;
            void'(m_q.pop_front());
        end
        @(negedge clk); rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        n_checks++; if (ev_count !== 4'd0) $display("FAIL empty_rd_count: got %0d want 0", ev_count); else n_pass++;
        n_checks++; if (ev_empty !== 1'b1 || ev_data !== 5'h00) $display("FAIL empty_rd_head: got %b/%h want 1/00", ev_empty, ev_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] d;
        @(negedge clk);
        button_data = 12'h0F0;
        // three ticks six cycles apart: second lands mid-scan, third while pending
        for (int k = 0; k < 15; k++) begin
            frame_latch = ((k % 6) < 3);
            @(negedge clk);
        end
        frame_latch = 1'b0;
        repeat (40) @(negedge clk);
        model_frame(12'h0F0);
        model_frame(12'h0F0);
        n_checks++; if (ev_count !== 4'(m_q.size())) $display("FAIL b2b_count: got %0d want %0d", ev_count, m_q.size()); else n_pass++;
        n_checks++; if (held !== m_held) $display("FAIL b2b_held: got %h want %h", held, m_held); else n_pass++;
        do_frame(12'h0F0, 0);
        model_frame(12'h0F0);
        n_checks++; if (ev_count !== 4'(m_q.size())) $display("FAIL b2b_next_count: got %0d want %0d", ev_count, m_q.size()); else n_pass++;
        n_checks++; if (held !== m_held) $display("FAIL b2b_next_held: got %h want %h", held, m_held); else n_pass++;
        while (m_q.size() > 0) begin
            pop_one(d);
            n_checks++; if (d !== m_q[0]) $display("FAIL b2b_drain: got %h want %h", d, m_q[0]); else n_pass++;
            void'(m_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [4:0] d;
        for (int f = 0; f < 3; f++) begin
            do_frame(12'h000, 0);
            model_frame(12'h000);
        end
        @(negedge clk);
        button_data = 12'h0FF;
        frame_latch = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) frame_latch = 1'b0;
        end
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (ev_count !== 4'd0 || ev_empty !== 1'b1) $display("FAIL rst_scan_fifo: got %0d/%b want 0/1", ev_count, ev_empty); else n_pass++;
        n_checks++; if (held !== 12'h000) $display("FAIL rst_scan_held: got %h want 000", held); else n_pass++;
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++; if (ev_count !== 4'd0) $display("FAIL rst_scan_idle: got %0d want 0", ev_count); else n_pass++;
        for (int f = 0; f < 3; f++) begin
            do_frame(12'h080, 0);
            model_frame(12'h080);
        end
        n_checks++; if (ev_count !== 4'd1) $display("FAIL rst_scan_count: got %0d want 1", ev_count); else n_pass++;
        n_checks++; if (ev_data !== 5'h17) $display("FAIL rst_scan_data: got %h want 17", ev_data); else n_pass++;
        n_checks++; if (held !== 12'h080) $display("FAIL rst_scan_held2: got %h want 080", held); else n_pass++;
        pop_one(d);
        void'(m_q.pop_front());
    endtask

    task automatic test_random();
        logic [11:0] cur = 12'h080;
        logic [4:0]  d;
        int          npop;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2) == 0) cur = 12'($urandom);
            do_frame(cur, 0);
            model_frame(cur);
            n_checks++; if (held !== m_held) $display("FAIL rnd_held: got %h want %h", held, m_held); else n_pass++;
            n_checks++; if (ev_count !== 4'(m_q.size())) $display("FAIL rnd_count: got %0d want %0d", ev_count, m_q.size()); else n_pass++;
            n_checks++; if (ev_overflow !== m_ovf) $display("FAIL rnd_ovf: got %b want %b", ev_overflow, m_ovf); else n_pass++;
            n_checks++; if (ev_data !== m_head()) $display("FAIL rnd_head: got %h want %h", ev_data, m_head()); else n_pass++;
            npop = $urandom_range(3);
            for (int p = 0; p < npop; p++) begin
                if (m_q.size() > 0) begin
                    pop_one(d);
                    n_checks++; if (d !== m_q[0]) $display("FAIL rnd_pop: got %h want %h", d, m_q[0]); else n_pass++;
                    void'(m_q.pop_front());
                end else begin
                    pop_one(d);
                    n_checks++; if (ev_count !== 4'd0) $display("FAIL rnd_pop_empty: got %0d want 0", ev_count); else n_pass++;
                end
            end
            if ($urandom_range(4) == 0) begin
                @(negedge clk); clr_ovf = 1'b1;
                @(negedge clk); clr_ovf = 1'b0;
                m_ovf = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_release_debounce();
        test_timing();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
